// File: rtl/event_dwell_timer.sv
// Times blockade events between an edgefall and the following edgerise, tracking the
// minimum and baseline samples, and queues one 64-bit record per event in an FWFT FIFO.
module event_dwell_timer #(
    parameter int DWELL_W    = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_DWELL  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [13:0]                   signal,
    input  logic                          edgefall,
    input  logic                          edgerise,
    input  logic [DWELL_W-1:0]            max_dwell,
    output logic [63:0]                   evt_data,
    output logic                          evt_valid,
    input  logic                          evt_rd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   glitch_cnt,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_EVENT,
        ST_EMIT
    } state_t;

    state_t               r_state;
    logic [DWELL_W-1:0]   r_dwell;
    logic [13:0]          r_min;
    logic [13:0]          r_baseline;
    logic                 r_timeout;
    logic [15:0]          r_glitchCnt;
    logic [15:0]          r_dropCnt;
    logic [63:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wrPtr;
    logic [AW-1:0]        r_rdPtr;
    logic [AW:0]          r_count;

    logic [DWELL_W-1:0]   w_effMax;
    logic [DWELL_W-1:0]   w_dwellNext;
    logic [13:0]          w_minNext;
    logic [23:0]          w_dwellField;
    logic [63:0]          w_record;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // A zero timeout setting means the longest representable dwell.
    assign w_effMax     = (max_dwell == '0) ? '1 : max_dwell;
    assign w_dwellNext  = r_dwell + DWELL_W'(1);
    assign w_minNext    = (signal < r_min) ? signal : r_min;
    assign w_dwellField = 24'(r_dwell);
    assign w_record     = {11'b0, r_timeout, w_dwellField, r_min, r_baseline};

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = (r_state == ST_EMIT) && !w_full;
    assign w_pop   = evt_rd && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dwell     <= '0;
            r_min       <= '0;
            r_baseline  <= '0;
            r_timeout   <= 1'b0;
            r_glitchCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && edgefall) begin
                        r_state    <= ST_IN_EVENT;
                        r_baseline <= signal;
                        r_min      <= signal;
                        r_dwell    <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_IN_EVENT: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dwell <= w_dwellNext;
                        r_min   <= w_minNext;
                        // A rise on the timeout cycle still counts as a normal end.
                        if (edgerise) begin
                            r_timeout <= 1'b0;
                            if (w_dwellNext < DWELL_W'(MIN_DWELL)) begin
                                r_state <= ST_IDLE;
                                if (r_glitchCnt != 16'hFFFF) begin
                                    r_glitchCnt <= r_glitchCnt + 16'd1;
                                end
                            end else begin
                                r_state <= ST_EMIT;
                            end
                        end else if (w_dwellNext == w_effMax) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dropCnt <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if ((r_state == ST_EMIT) && w_full && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_record;
        end
    end

    assign evt_data   = w_empty ? 64'd0 : r_mem[r_rdPtr];
    assign evt_valid  = !w_empty;
    assign fifo_level = r_count;
    assign drop_count = r_dropCnt;
    assign glitch_cnt = r_glitchCnt;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_event_dwell_timer.sv
// Directed bench for event_dwell_timer: a per-cycle vector table for short sequences
// and hand-written sequences for long events, timeouts, overflow and reset.
module tb_event_dwell_timer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [13:0] signal;
    logic        edgefall;
    logic        edgerise;
    logic [23:0] max_dwell;
    logic [63:0] evt_data;
    logic        evt_valid;
    logic        evt_rd;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;
    logic [15:0] glitch_cnt;
    logic        busy;

    int checkCount = 0;
    int failCount  = 0;

    event_dwell_timer #(.DWELL_W(24), .FIFO_DEPTH(16), .MIN_DWELL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .signal     (signal),
        .edgefall   (edgefall),
        .edgerise   (edgerise),
        .max_dwell  (max_dwell),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .evt_rd     (evt_rd),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .glitch_cnt (glitch_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        fall;
        logic        rise;
        logic        rd;
        logic [13:0] sig;
        logic        expBusy;
        logic        expValid;
        logic [4:0]  expLevel;
        logic [15:0] expGlitch;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [63:0] mkRec(input logic tmo, input int dwell,
                                          input int minV, input int baseV);
        logic [23:0] d;
        logic [13:0] m;
        logic [13:0] b;
        d = 24'(dwell);
        m = 14'(minV);
        b = 14'(baseV);
        return {11'b0, tmo, d, m, b};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic en, input logic fall, input logic rise,
                                 input logic rd, input logic [13:0] sig);
        enable   = en;
        edgefall = fall;
        edgerise = rise;
        evt_rd   = rd;
        signal   = sig;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] rec;
        int          base;

        rst_n     = 1'b0;
        enable    = 1'b0;
        signal    = '0;
        edgefall  = 1'b0;
        edgerise  = 1'b0;
        evt_rd    = 1'b0;
        max_dwell = 24'd100;

        rec = mkRec(1'b0, 4, 140, 200);
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd0,   1'b0, 1'b0, 5'd0, 16'd0, 64'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'd50,  1'b0, 1'b0, 5'd0, 16'd0, 64'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 14'd100, 1'b1, 1'b0, 5'd0, 16'd0, 64'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd90,  1'b1, 1'b0, 5'd0, 16'd0, 64'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'd95,  1'b0, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 14'd200, 1'b1, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd150, 1'b1, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd160, 1'b1, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd170, 1'b1, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 14'd140, 1'b1, 1'b0, 5'd0, 16'd1, 64'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd0,   1'b0, 1'b1, 5'd1, 16'd1, rec};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'd300, 1'b0, 1'b1, 5'd1, 16'd1, rec};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 14'd300, 1'b1, 1'b1, 5'd1, 16'd1, rec};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd250, 1'b0, 1'b1, 5'd1, 16'd1, rec};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd0,   1'b0, 1'b1, 5'd1, 16'd1, rec};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd0,   1'b0, 1'b0, 5'd0, 16'd1, 64'd0};

        #12;
        checkOutput("reset evt_valid", 64'(evt_valid), 64'd0);
        checkOutput("reset evt_data", evt_data, 64'd0);
        checkOutput("reset fifo_level", 64'(fifo_level), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset counters", {32'd0, drop_count, glitch_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Glitch, same-cycle fall/rise, minimum-length event, idle rise, abort.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].en, vecs[i].fall, vecs[i].rise, vecs[i].rd, vecs[i].sig);
            checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d valid", i), 64'(evt_valid), 64'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d level", i), 64'(fifo_level), 64'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d glitch", i), 64'(glitch_cnt), 64'(vecs[i].expGlitch));
            checkOutput($sformatf("vec%0d data", i), evt_data, vecs[i].expData);
        end

        // Basic 50-cycle event.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'd8000);
        for (int j = 1; j <= 50; j++) begin
            applyStimulus(1'b1, 1'b0, (j == 50), 1'b0, (j <= 3) ? 14'd5000 : 14'd6000);
        end
        checkOutput("basic emit busy", 64'(busy), 64'd1);
        checkOutput("basic not yet valid", 64'(evt_valid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd6000);
        checkOutput("basic valid", 64'(evt_valid), 64'd1);
        checkOutput("basic data", evt_data, mkRec(1'b0, 50, 5000, 8000));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'd6000);
        checkOutput("basic popped", 64'(evt_valid), 64'd0);

        // Timeout with no rise, then a stray rise in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'd3000);
        for (int j = 1; j <= 99; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd3000);
        end
        checkOutput("timeout still busy", 64'(busy), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd3000);
        checkOutput("timeout emit busy", 64'(busy), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd3000);
        checkOutput("timeout valid", 64'(evt_valid), 64'd1);
        checkOutput("timeout data", evt_data, mkRec(1'b1, 100, 3000, 3000));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 14'd3000);
        checkOutput("idle rise ignored", 64'(busy), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'd3000);
        checkOutput("timeout popped", 64'(fifo_level), 64'd0);

        // Rise on the exact timeout cycle wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'd3000);
        for (int j = 1; j <= 100; j++) begin
            applyStimulus(1'b1, 1'b0, (j == 100), 1'b0, 14'd2500);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd2500);
        checkOutput("coincide valid", 64'(evt_valid), 64'd1);
        checkOutput("coincide data", evt_data, mkRec(1'b0, 100, 2500, 3000));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'd0);

        // Twenty events into a 16-deep FIFO with no reads.
        for (int i = 0; i < 20; i++) begin
            base = 1000 + i * 10;
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'(base));
            for (int j = 1; j <= 4 + i; j++) begin
                applyStimulus(1'b1, 1'b0, (j == 4 + i), 1'b0, 14'(500 + i));
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
        end
        checkOutput("overflow level", 64'(fifo_level), 64'd16);
        checkOutput("overflow drops", 64'(drop_count), 64'd4);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("pop%0d valid", i), 64'(evt_valid), 64'd1);
            checkOutput($sformatf("pop%0d data", i), evt_data,
                        mkRec(1'b0, 4 + i, 500 + i, 1000 + i * 10));
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'd0);
        end
        checkOutput("drained", 64'(evt_valid), 64'd0);

        // Three records queued plus an open event, then asynchronous reset.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'd4000);
            for (int j = 1; j <= 5; j++) begin
                applyStimulus(1'b1, 1'b0, (j == 5), 1'b0, 14'd3500);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
        end
        checkOutput("queued level", 64'(fifo_level), 64'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'd4000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd3900);
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", 64'(evt_valid), 64'd0);
        checkOutput("async reset level", 64'(fifo_level), 64'd0);
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset counters", {32'd0, drop_count, glitch_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 14'd0);
        checkOutput("post-reset idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
